lcd_write_engine: RTL and testbench

Byte-level HD44780 bus driver that sits directly downstream of the LCD main controller. It accepts one command or data byte per start pulse and generates the LCD pin sequence: RS/DB setup, E pulse, hold, then the command execution wait. It returns a one-cycle `finish` pulse, which the controller consumes as `lcd_finish`. All pin timing is expressed in clock cycles through parameters.

---
 rtl/lcd_write_engine.sv | 139 +++++++++++++
 tb/tb_lcd_write_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/lcd_write_engine.sv
// lcd_write_engine: HD44780 byte writer (setup, E pulse, hold, execution wait, finish pulse).
// Define LCD_4BIT_EN to split each byte into two nibble transfers on lcd_db[7:4].
module lcd_write_engine #(
    parameter int T_AS        = 2,
    parameter int T_PW        = 12,
    parameter int T_H         = 1,
    parameter int T_EXEC      = 1850,
    parameter int T_EXEC_LONG = 76000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rs_in,
    input  logic [7:0] data_in,
    output logic       busy,
    output logic       finish,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_db
);
    localparam int M0   = T_AS > T_PW ? T_AS : T_PW;
    localparam int M1   = M0 > T_H ? M0 : T_H;
    localparam int M2   = M1 > T_EXEC ? M1 : T_EXEC;
    localparam int MAXP = M2 > T_EXEC_LONG ? M2 : T_EXEC_LONG;
    localparam int CW   = $clog2(MAXP) + 1;

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, EXEC, DONE} state_t;

    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d, db_q, db_d;
    logic rs_q, rs_d, busy_q, fin_q, e_q;
    logic accept, zero, long_wait;
`ifdef LCD_4BIT_EN
    logic nib_q, nib_d;
`endif

    assign accept    = start && (state_q == IDLE || state_q == DONE);
    assign zero      = cnt_q == '0;
    // clear (0x01) and return-home (0x02/0x03) need the long execution wait
    assign long_wait = !rs_q && data_q[7:2] == 6'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        rs_d    = rs_q;
`ifdef LCD_4BIT_EN
        nib_d   = nib_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = SETUP;
                    cnt_d   = CW'(T_AS - 1);
                    data_d  = data_in;
                    rs_d    = rs_in;
`ifdef LCD_4BIT_EN
                    nib_d   = 1'b0;
`endif
                end
            end
            SETUP: begin
                if (zero) begin
                    state_d = PULSE;
                    cnt_d   = CW'(T_PW - 1);
                end else cnt_d = cnt_q - 1'b1;
            end
            PULSE: begin
                if (zero) begin
                    state_d = HOLD;
                    cnt_d   = CW'(T_H - 1);
                end else cnt_d = cnt_q - 1'b1;
            end
            HOLD: begin
                if (!zero) cnt_d = cnt_q - 1'b1;
`ifdef LCD_4BIT_EN
                else if (!nib_q) begin
                    state_d = SETUP;
                    cnt_d   = CW'(T_AS - 1);
                    nib_d   = 1'b1;
                end
`endif
                else begin
                    state_d = EXEC;
                    cnt_d   = long_wait ? CW'(T_EXEC_LONG - 1) : CW'(T_EXEC - 1);
                end
            end
            EXEC: begin
                if (zero) state_d = DONE;
                else cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
`ifdef LCD_4BIT_EN
        db_d = {nib_d ? data_d[3:0] : data_d[7:4], 4'h0};
`else
        db_d = data_d;
`endif
    end

    // pin outputs are registered from next-state so lcd_e cannot glitch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            db_q    <= '0;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
            e_q     <= 1'b0;
`ifdef LCD_4BIT_EN
            nib_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            rs_q    <= rs_d;
            db_q    <= db_d;
            busy_q  <= state_d inside {SETUP, PULSE, HOLD, EXEC};
            fin_q   <= state_d == DONE;
            e_q     <= state_d == PULSE;
`ifdef LCD_4BIT_EN
            nib_q   <= nib_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign finish = fin_q;
    assign lcd_e  = e_q;
    assign lcd_rs = rs_q;
    assign lcd_rw = 1'b0;
    assign lcd_db = db_q;
endmodule

// File: tb/tb_lcd_write_engine.sv
// tb_lcd_write_engine: random and directed byte writes checked each cycle against a transfer-level timeline model.
module tb_lcd_write_engine;
    localparam int T_AS = 2, T_PW = 12, T_H = 1, T_EXEC = 20, T_EXEC_LONG = 100;
    localparam int P = T_AS + T_PW + T_H;
`ifdef LCD_4BIT_EN
    localparam int NPH = 2, LAT = 50, LAT_LONG = 130;
`else
    localparam int NPH = 1, LAT = 35, LAT_LONG = 115;
`endif

    logic clk = 0, rst = 1, start = 0, rs_in = 0;
    logic [7:0] data_in = 0;
    logic busy, finish, lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_db;

    lcd_write_engine #(.T_AS(T_AS), .T_PW(T_PW), .T_H(T_H), .T_EXEC(T_EXEC), .T_EXEC_LONG(T_EXEC_LONG)) dut (
        .clk(clk), .rst(rst), .start(start), .rs_in(rs_in), .data_in(data_in),
        .busy(busy), .finish(finish), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int lat(input logic r, input logic [7:0] d);
        return NPH * P + ((!r && d[7:2] == 6'd0) ? T_EXEC_LONG : T_EXEC);
    endfunction

    // model: one transfer = timeline of length tot starting at accept edge k
    bit act = 0;
    int cyc = 0, k = 0, tot = 0;
    logic mrs = 0;
    logic [7:0] mdata = 0;

    always @(posedge clk) begin
        cyc++;
        if (rst) act = 0;
        else begin
            if (act && cyc - k > tot) act = 0;
            if (start && !act) begin
                act = 1; k = cyc; mrs = rs_in; mdata = data_in; tot = lat(rs_in, data_in);
            end
        end
    end

    always @(negedge clk) begin : cmp
        int t, ph;
        logic [7:0] edb;
        t   = cyc - k;
        ph  = t % P;
        edb = NPH == 2 ? (t < P ? {mdata[7:4], 4'h0} : {mdata[3:0], 4'h0}) : mdata;
        chk("busy", busy, int'(act && t < tot));
        chk("finish", finish, int'(act && t == tot));
        chk("lcd_e", lcd_e, int'(act && t < NPH * P && ph >= T_AS && ph < T_AS + T_PW));
        chk("lcd_rw", lcd_rw, 0);
        if (act && t < tot) begin
            chk("lcd_rs", lcd_rs, mrs);
            chk("lcd_db", lcd_db, edb);
        end
        if (rst) begin
            chk("rst_db", lcd_db, 0);
            chk("rst_rs", lcd_rs, 0);
        end
    end

    logic       e_at [0:511];
    logic [7:0] db_at[0:511];

    // caller is at a negedge; returns at the negedge where finish is seen
    task automatic xfer(input logic r, input logic [7:0] d, input int exp, input bit noise, input string nm);
        int n = 0;
        start = 1; rs_in = r; data_in = d;
        @(negedge clk);
        start = 0; rs_in = 1'($urandom); data_in = 8'($urandom);
        e_at[0] = lcd_e; db_at[0] = lcd_db;
        if (!noise) begin
            chk({nm, "_db0"}, lcd_db, NPH == 2 ? {d[7:4], 4'h0} : d);
            chk({nm, "_rs0"}, lcd_rs, r);
        end
        while (!finish && n < 400) begin
            start = noise && n < exp - 1 && $urandom_range(0, 7) == 0;
            rs_in = 1'($urandom); data_in = 8'($urandom);
            @(negedge clk);
            n++;
            e_at[n] = lcd_e; db_at[n] = lcd_db;
        end
        start = 0;
        chk({nm, "_lat"}, n, exp);
    endtask

    initial begin : wd
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int nf;
        logic r;
        logic [7:0] d;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_e", lcd_e, 0);
        chk("reset_db", lcd_db, 0);
        chk("reset_finish", finish, 0);
        rst = 0;
        repeat (2) @(negedge clk);

        xfer(1, 8'h41, LAT, 0, "data41");
        chk("e_n1", e_at[1], 0);
        chk("e_n2", e_at[2], 1);
        chk("e_n13", e_at[13], 1);
        chk("e_n14", e_at[14], 0);
        repeat (3) @(negedge clk);

        xfer(0, 8'h01, LAT_LONG, 0, "clear");
        repeat (2) @(negedge clk);
        xfer(1, 8'h01, LAT, 0, "data01");
        repeat (2) @(negedge clk);

        xfer(1, 8'hA5, LAT, 0, "nib");
        chk("nib_db_p1", db_at[2], NPH == 2 ? 8'hA0 : 8'hA5);
        chk("nib_db_p2", db_at[17], NPH == 2 ? 8'h50 : 8'hA5);
        chk("nib_e_p2", e_at[17], NPH == 2 ? 1 : 0);

        xfer(1, 8'h3C, LAT, 0, "b2b_a");
        xfer(0, 8'h02, LAT_LONG, 0, "b2b_home");
        repeat (2) @(negedge clk);

        // start during EXEC must be ignored
        start = 1; rs_in = 1; data_in = 8'h41;
        @(negedge clk);
        start = 0;
        repeat (31) @(negedge clk);
        start = 1; rs_in = 0; data_in = 8'h55;
        @(negedge clk);
        start = 0;
        chk("ign_db", lcd_db, NPH == 2 ? 8'h10 : 8'h41);
        chk("ign_busy", busy, 1);
        nf = 0;
        repeat (100) begin @(negedge clk); nf += int'(finish); end
        chk("ign_nfinish", nf, 1);

        // reset while E is high
        start = 1; rs_in = 1; data_in = 8'h41;
        @(negedge clk);
        start = 0;
        repeat (8) @(negedge clk);
        chk("pre_rst_e", lcd_e, 1);
        #1 rst = 1;
        #1;
        chk("rst_e_now", lcd_e, 0);
        chk("rst_busy_now", busy, 0);
        repeat (3) @(negedge clk);
        rst = 0;
        nf = 0;
        repeat (200) begin @(negedge clk); nf += int'(finish); end
        chk("rst_nfinish", nf, 0);

        repeat (30) begin
            r = 1'($urandom);
            d = $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 3)) : 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            xfer(r, d, lat(r, d), 1, "rnd");
        end
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
